// File: rtl/mc_controller.sv
// Multicycle RV32I control unit: Moore FSM sequencing shared ALU, memory port, IR and PC.
// Latency: 3-5 cycles per instruction with zero-wait memory; each stall cycle adds one.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold state and request outputs until mem_ready.
//
// Optional feature macro: MC_ILLEGAL_TRAP_EN
//   defined   -> unknown opcode parks the FSM in TRAP (illegal=1) until reset
//   undefined -> unknown opcode retires as a NOP; illegal is tied 0
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   op, funct3, funct7b5    instruction fields from the instruction register
//   Zero                    ALU result == 0
//   mem_ready               memory completes current request this cycle
//   mem_req, MemWrite       memory request valid / store strobe
//   IRWrite, PCWrite        load instruction register / PC
//   AdrSrc                  memory address select (0 PC, 1 ALUOut)
//   ALUSrcA, ALUSrcB        ALU operand selects
//   ResultSrc, ImmSrc       result mux / immediate format selects
//   RegWrite                register-file write
//   ALUControl              ALU operation
//   retire                  one-cycle pulse when an instruction completes
//   illegal                 sticky illegal-opcode flag
module mc_controller (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic [3:0] ALUControl,
  output logic       retire,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b100;

  state_t state, next_state;

  // Opcodes this controller knows how to sequence.
  function automatic logic op_known(input logic [6:0] o);
    return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) ||
           (o == OP_BR) || (o == OP_JAL) || (o == OP_LUI);
  endfunction

  // Shared funct decode for R- and I-type. Subtract needs both R-type and
  // instr[30]: addi uses instr[30] as an immediate bit. srai/sra both use it.
  function automatic logic [3:0] funct_alu(input logic [2:0] f3,
                                            input logic       f7b5,
                                            input logic       rtype);
    logic [3:0] a;
    case (f3)
      3'b000:  a = (rtype && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  a = ALU_SLL;
      3'b010:  a = ALU_SLT;
      3'b011:  a = ALU_SLTU;
      3'b100:  a = ALU_XOR;
      3'b101:  a = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  a = ALU_OR;
      default: a = ALU_AND;
    endcase
    return a;
  endfunction

  // Branch compare: equality via sub, signed/unsigned less-than via slt/sltu.
  function automatic logic [3:0] branch_alu(input logic [2:0] f3);
    logic [3:0] a;
    case (f3[2:1])
      2'b10:   a = ALU_SLT;
      2'b11:   a = ALU_SLTU;
      default: a = ALU_SUB;
    endcase
    return a;
  endfunction

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_FETCH;
    else          state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_R:         next_state = S_EXECR;
          OP_I:         next_state = S_EXECI;
          OP_BR:        next_state = S_BRANCH;
          OP_JAL:       next_state = S_JAL;
          OP_LUI:       next_state = S_LUI;
`ifdef MC_ILLEGAL_TRAP_EN
          default:      next_state = S_TRAP;
`else
          default:      next_state = S_FETCH;
`endif
        endcase
      end
      // op[5] separates sw (0100011) from lw (0000011).
      S_MEMADR:   next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) next_state = S_MEMWB;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: if (mem_ready) next_state = S_FETCH;
      S_EXECR:    next_state = S_ALUWB;
      S_EXECI:    next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_JAL:      next_state = S_ALUWB;
      S_LUI:      next_state = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
      S_TRAP:     next_state = S_TRAP;
`else
      S_TRAP:     next_state = S_FETCH;
`endif
      default:    next_state = S_FETCH;
    endcase
  end

  // Output logic: Moore on state; PCWrite/IRWrite additionally see mem_ready
  // and Zero, and the completing MEMWRITE cycle retires on mem_ready.
  always_comb begin
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ImmSrc     = IMM_I;
    RegWrite   = 1'b0;
    ALUControl = ALU_ADD;
    retire     = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        // Precompute branch target into ALUOut.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = IMM_B;
`ifndef MC_ILLEGAL_TRAP_EN
        retire  = !op_known(op);
`endif
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = op[5] ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        retire    = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        retire   = mem_ready;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = funct_alu(funct3, funct7b5, 1'b1);
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = funct_alu(funct3, funct7b5, 1'b0);
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = branch_alu(funct3);
        // funct3[0] inverts the sense, funct3[2] selects the lt family
        // where "taken" means a non-zero comparison result.
        PCWrite    = funct3[2] ^ funct3[0] ^ Zero;
        retire     = 1'b1;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        ImmSrc  = IMM_U;
      end
      S_TRAP: begin
`ifdef MC_ILLEGAL_TRAP_EN
        illegal = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle expected outputs queued on drive, checked at negedge.
// Latency: each step is one clock; checks land half a cycle after inputs change.
// Backpressure: mem_ready stalls are driven explicitly per step.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;
  logic       mem_req, MemWrite, IRWrite, PCWrite, AdrSrc;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ImmSrc;
  logic       RegWrite;
  logic [3:0] ALUControl;
  logic       retire, illegal;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .ALUControl(ALUControl), .retire(retire), .illegal(illegal)
  );

  typedef struct packed {
    logic       mem_req;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       adrsrc;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] ressrc;
    logic [2:0] immsrc;
    logic       regwrite;
    logic [3:0] alu;
    logic       retire;
    logic       illegal;
  } out_t;

  out_t obs;
  assign obs = {mem_req, MemWrite, IRWrite, PCWrite, AdrSrc, ALUSrcA, ALUSrcB,
                ResultSrc, ImmSrc, RegWrite, ALUControl, retire, illegal};

  out_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  // Expected output vectors per FSM phase, written from the control table.
  function automatic out_t e_fetch(input logic r);
    out_t e = '0;
    e.mem_req = 1'b1; e.irwrite = r; e.pcwrite = r;
    e.srcb = 2'b10; e.ressrc = 2'b10;
    return e;
  endfunction
  function automatic out_t e_decode(input logic ret);
    out_t e = '0;
    e.srca = 2'b01; e.srcb = 2'b01; e.immsrc = 3'b010; e.retire = ret;
    return e;
  endfunction
  function automatic out_t e_memadr(input logic is_sw);
    out_t e = '0;
    e.srca = 2'b10; e.srcb = 2'b01; e.immsrc = is_sw ? 3'b001 : 3'b000;
    return e;
  endfunction
  function automatic out_t e_memread();
    out_t e = '0;
    e.mem_req = 1'b1; e.adrsrc = 1'b1;
    return e;
  endfunction
  function automatic out_t e_memwb();
    out_t e = '0;
    e.ressrc = 2'b01; e.regwrite = 1'b1; e.retire = 1'b1;
    return e;
  endfunction
  function automatic out_t e_memwrite(input logic r);
    out_t e = '0;
    e.mem_req = 1'b1; e.adrsrc = 1'b1; e.memwrite = 1'b1; e.retire = r;
    return e;
  endfunction
  function automatic out_t e_exec(input logic imm, input logic [3:0] alu);
    out_t e = '0;
    e.srca = 2'b10; e.srcb = imm ? 2'b01 : 2'b00; e.alu = alu;
    return e;
  endfunction
  function automatic out_t e_aluwb();
    out_t e = '0;
    e.regwrite = 1'b1; e.retire = 1'b1;
    return e;
  endfunction
  function automatic out_t e_branch(input logic [3:0] alu, input logic pcw);
    out_t e = '0;
    e.srca = 2'b10; e.alu = alu; e.pcwrite = pcw; e.retire = 1'b1;
    return e;
  endfunction
  function automatic out_t e_jal();
    out_t e = '0;
    e.srca = 2'b01; e.srcb = 2'b10; e.pcwrite = 1'b1;
    return e;
  endfunction
  function automatic out_t e_lui();
    out_t e = '0;
    e.srca = 2'b11; e.srcb = 2'b01; e.immsrc = 3'b100;
    return e;
  endfunction
  function automatic out_t e_trap();
    out_t e = '0;
    e.illegal = 1'b1;
    return e;
  endfunction

  // One clock step: drive mem_ready, queue the expectation, check at negedge.
  task automatic cyc(input logic rdy, input out_t e, input string tag);
    out_t  x;
    string t;
    mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    x = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === x) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs, x);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z);
    op = o; funct3 = f3; funct7b5 = f7; Zero = z;
  endtask

  initial begin
    reset_n = 1'b0; mem_ready = 1'b0;
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);

    // Reset: FETCH values, strobes follow mem_ready.
    cyc(1'b0, e_fetch(1'b0), "rst_rdy0");
    cyc(1'b1, e_fetch(1'b1), "rst_rdy1");
    cyc(1'b0, e_fetch(1'b0), "rst_rdy0b");
    reset_n = 1'b1;
    cyc(1'b0, e_fetch(1'b0), "fetch_wait");

    // lw, zero-wait: 5 cycles.
    cyc(1'b1, e_fetch(1'b1),    "lw_fetch");
    cyc(1'b1, e_decode(1'b0),   "lw_decode");
    cyc(1'b1, e_memadr(1'b0),   "lw_memadr");
    cyc(1'b1, e_memread(),      "lw_memread");
    cyc(1'b1, e_memwb(),        "lw_memwb");

    // lw with MEMREAD stalled 3 cycles: 8 cycles.
    cyc(1'b1, e_fetch(1'b1),    "lws_fetch");
    cyc(1'b0, e_decode(1'b0),   "lws_decode_rdy_ignored");
    cyc(1'b1, e_memadr(1'b0),   "lws_memadr");
    cyc(1'b0, e_memread(),      "lws_stall1");
    cyc(1'b0, e_memread(),      "lws_stall2");
    cyc(1'b0, e_memread(),      "lws_stall3");
    cyc(1'b1, e_memread(),      "lws_memread");
    cyc(1'b1, e_memwb(),        "lws_memwb");

    // sw with 2 wait cycles in MEMWRITE.
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    cyc(1'b1, e_fetch(1'b1),     "sw_fetch");
    cyc(1'b1, e_decode(1'b0),    "sw_decode");
    cyc(1'b1, e_memadr(1'b1),    "sw_memadr");
    cyc(1'b0, e_memwrite(1'b0),  "sw_wait1");
    cyc(1'b0, e_memwrite(1'b0),  "sw_wait2");
    cyc(1'b1, e_memwrite(1'b1),  "sw_done");

    // Branches with Zero forced.
    set_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
    cyc(1'b1, e_fetch(1'b1), "beq_fetch");
    cyc(1'b1, e_decode(1'b0), "beq_decode");
    cyc(1'b1, e_branch(4'b0001, 1'b1), "beq_z1_taken");
    set_instr(7'b1100011, 3'b001, 1'b0, 1'b1);
    cyc(1'b1, e_fetch(1'b1), "bne_fetch");
    cyc(1'b1, e_decode(1'b0), "bne_decode");
    cyc(1'b1, e_branch(4'b0001, 1'b0), "bne_z1_not_taken");
    set_instr(7'b1100011, 3'b100, 1'b0, 1'b0);
    cyc(1'b1, e_fetch(1'b1), "blt_fetch");
    cyc(1'b1, e_decode(1'b0), "blt_decode");
    cyc(1'b1, e_branch(4'b0101, 1'b1), "blt_z0_taken");
    set_instr(7'b1100011, 3'b111, 1'b0, 1'b0);
    cyc(1'b1, e_fetch(1'b1), "bgeu_fetch");
    cyc(1'b1, e_decode(1'b0), "bgeu_decode");
    cyc(1'b1, e_branch(4'b0110, 1'b0), "bgeu_z0_not_taken");

    // ALU decode.
    set_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
    cyc(1'b1, e_fetch(1'b1), "sub_fetch");
    cyc(1'b0, e_decode(1'b0), "sub_decode");
    cyc(1'b0, e_exec(1'b0, 4'b0001), "sub_execr");
    cyc(1'b0, e_aluwb(), "sub_aluwb");
    set_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
    cyc(1'b1, e_fetch(1'b1), "addi_fetch");
    cyc(1'b1, e_decode(1'b0), "addi_decode");
    cyc(1'b1, e_exec(1'b1, 4'b0000), "addi_b30_is_add");
    cyc(1'b1, e_aluwb(), "addi_aluwb");
    set_instr(7'b0010011, 3'b101, 1'b1, 1'b0);
    cyc(1'b1, e_fetch(1'b1), "srai_fetch");
    cyc(1'b1, e_decode(1'b0), "srai_decode");
    cyc(1'b1, e_exec(1'b1, 4'b1001), "srai_execi");
    cyc(1'b1, e_aluwb(), "srai_aluwb");
    set_instr(7'b0110011, 3'b110, 1'b0, 1'b0);
    cyc(1'b1, e_fetch(1'b1), "or_fetch");
    cyc(1'b1, e_decode(1'b0), "or_decode");
    cyc(1'b1, e_exec(1'b0, 4'b0011), "or_execr");
    cyc(1'b1, e_aluwb(), "or_aluwb");

    // jal and lui: 4 cycles each.
    set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, e_fetch(1'b1), "jal_fetch");
    cyc(1'b1, e_decode(1'b0), "jal_decode");
    cyc(1'b1, e_jal(), "jal_exec");
    cyc(1'b1, e_aluwb(), "jal_aluwb");
    set_instr(7'b0110111, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, e_fetch(1'b1), "lui_fetch");
    cyc(1'b1, e_decode(1'b0), "lui_decode");
    cyc(1'b1, e_lui(), "lui_exec");
    cyc(1'b1, e_aluwb(), "lui_aluwb");

    // Reset mid-instruction aborts a stalled load.
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    cyc(1'b1, e_fetch(1'b1), "abort_fetch");
    cyc(1'b1, e_decode(1'b0), "abort_decode");
    cyc(1'b1, e_memadr(1'b0), "abort_memadr");
    cyc(1'b0, e_memread(), "abort_memread");
    reset_n = 1'b0;
    cyc(1'b0, e_fetch(1'b0), "abort_in_reset");
    reset_n = 1'b1;
    cyc(1'b1, e_fetch(1'b1), "abort_refetch");
    cyc(1'b1, e_decode(1'b0), "abort_redecode");
    cyc(1'b1, e_memadr(1'b0), "abort_rememadr");
    cyc(1'b1, e_memread(), "abort_rememread");
    cyc(1'b1, e_memwb(), "abort_rememwb");

    // Unknown opcode.
    set_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, e_fetch(1'b1), "ill_fetch");
`ifdef MC_ILLEGAL_TRAP_EN
    cyc(1'b1, e_decode(1'b0), "ill_decode");
    cyc(1'b1, e_trap(), "trap1");
    cyc(1'b1, e_trap(), "trap2");
    cyc(1'b0, e_trap(), "trap3");
    reset_n = 1'b0;
    cyc(1'b1, e_fetch(1'b1), "trap_reset");
    reset_n = 1'b1;
    set_instr(7'b0110111, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, e_fetch(1'b1), "trap_exit_fetch");
    cyc(1'b1, e_decode(1'b0), "trap_exit_decode");
`else
    cyc(1'b1, e_decode(1'b1), "ill_nop_retire");
    cyc(1'b0, e_fetch(1'b0), "ill_back_fetch");
    cyc(1'b1, e_fetch(1'b1), "ill_fetch_next");
    set_instr(7'b0110111, 3'b000, 1'b0, 1'b0);
    cyc(1'b1, e_decode(1'b0), "ill_next_decode");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
